// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer.
// Divider FSM encoding and default divider latency.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_RUN,
      DIV_DONE
   } DivState_t;

   localparam int DIV_CYCLES_DEFAULT = 36;

endpackage

// File: rtl/pipe_ctrl_div_seq.sv
// Iterative-divider sequencer: launch, countdown, one-cycle done, abort.
// freeze holds everything while the data cache stalls the pipe.
module pipe_ctrl_div_seq
   import pipe_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
   parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      freeze,
   input  logic      abort,
   input  logic      launch,
   output DivState_t state_o
);

   DivState_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!freeze) begin
         if (abort) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
         end else begin
            unique case (state_q)
               DIV_IDLE: begin
                  if (launch) begin
                     state_d = DIV_RUN;
                     cnt_d   = CNT_W'(DIV_CYCLES - 1);
                  end
               end
               DIV_RUN: begin
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1))
                     state_d = DIV_DONE;
               end
               DIV_DONE: state_d = DIV_IDLE;
               default:  state_d = DIV_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: turns stall/flush sources into per-stage
// write enables and flush strobes for the six-stage core.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
   parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic ICache_Busy,
   input  logic DCache_Busy,
   input  logic EXE_IsDiv,
   input  logic ID_LoadUse,
   input  logic EXE_Redirect,
   input  logic MEM_ExcValid,
   output logic PC_Wr,
   output logic ID_Wr,
   output logic EXE_Wr,
   output logic MEM_Wr,
   output logic MEM2_Wr,
   output logic WB_Wr,
   output logic ID_Flush,
   output logic EXE_Flush,
   output logic MEM_Flush,
   output logic MEM2_Flush,
   output logic WB_Flush,
   output logic Div_Start,
   output logic Div_Cancel,
   output logic Div_Busy,
   output logic Squash_Pending
);

   DivState_t div_state;
   logic      exc_take;
   logic      launch;
   logic      redir_take;
   logic      squash_q, squash_d;

   assign exc_take = MEM_ExcValid && !DCache_Busy;
   assign launch   = EXE_IsDiv && !DCache_Busy && !MEM_ExcValid;

   pipe_ctrl_div_seq #(
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_div_seq (
      .clk     (clk),
      .rst     (rst),
      .freeze  (DCache_Busy),
      .abort   (exc_take),
      .launch  (launch),
      .state_o (div_state)
   );

   always_comb begin
      {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, MEM2_Wr, WB_Wr} = '1;
      {ID_Flush, EXE_Flush, MEM_Flush, MEM2_Flush, WB_Flush} = '0;
      Div_Start  = 1'b0;
      Div_Cancel = 1'b0;
      redir_take = 1'b0;
      if (DCache_Busy) begin
         {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, MEM2_Wr, WB_Wr} = '0;
      end else if (MEM_ExcValid) begin
         {ID_Flush, EXE_Flush, MEM_Flush} = 3'b111;
         Div_Cancel = (div_state != DIV_IDLE);
      end else if (div_state == DIV_RUN) begin
         {PC_Wr, ID_Wr, EXE_Wr} = 3'b000;
         MEM_Flush = 1'b1;
      end else if (div_state == DIV_IDLE && EXE_IsDiv) begin
         Div_Start = 1'b1;
         {PC_Wr, ID_Wr, EXE_Wr} = 3'b000;
         MEM_Flush = 1'b1;
      end else if (ID_LoadUse) begin
         {PC_Wr, ID_Wr} = 2'b00;
         EXE_Flush = 1'b1;
      end else if (EXE_Redirect) begin
         redir_take = 1'b1;
         ID_Flush   = 1'b1;
      end else if (ICache_Busy) begin
         {PC_Wr, ID_Wr} = 2'b00;
         ID_Flush = 1'b1;
      end
      // an owed squash keeps killing the stale fetch until it lands
      if (squash_q && !DCache_Busy)
         ID_Flush = 1'b1;
      if (!rst) begin
         {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, MEM2_Wr, WB_Wr} = '0;
         {ID_Flush, EXE_Flush, MEM_Flush, MEM2_Flush, WB_Flush} = '1;
         Div_Start  = 1'b0;
         Div_Cancel = 1'b0;
      end
   end

   always_comb begin
      squash_d = squash_q;
      if (!DCache_Busy) begin
         if ((exc_take || redir_take) && ICache_Busy)
            squash_d = 1'b1;
         else if (!ICache_Busy)
            squash_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         squash_q <= 1'b0;
      else
         squash_q <= squash_d;
   end

   assign Div_Busy       = rst && (div_state == DIV_RUN);
   assign Squash_Pending = rst && squash_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
// Inputs change #1 after posedge; outputs are sampled at negedge.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic ICache_Busy, DCache_Busy, EXE_IsDiv;
   logic ID_LoadUse, EXE_Redirect, MEM_ExcValid;
   logic PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, MEM2_Wr, WB_Wr;
   logic ID_Flush, EXE_Flush, MEM_Flush, MEM2_Flush, WB_Flush;
   logic Div_Start, Div_Cancel, Div_Busy, Squash_Pending;

   int checks = 0;
   int failures = 0;

   logic [5:0] wr;
   logic [4:0] fl;
   assign wr = {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, MEM2_Wr, WB_Wr};
   assign fl = {ID_Flush, EXE_Flush, MEM_Flush, MEM2_Flush, WB_Flush};

   always #5 clk = ~clk;

   pipe_ctrl #(.DIV_CYCLES(36)) dut (
      .clk            (clk),
      .rst            (rst),
      .ICache_Busy    (ICache_Busy),
      .DCache_Busy    (DCache_Busy),
      .EXE_IsDiv      (EXE_IsDiv),
      .ID_LoadUse     (ID_LoadUse),
      .EXE_Redirect   (EXE_Redirect),
      .MEM_ExcValid   (MEM_ExcValid),
      .PC_Wr          (PC_Wr),
      .ID_Wr          (ID_Wr),
      .EXE_Wr         (EXE_Wr),
      .MEM_Wr         (MEM_Wr),
      .MEM2_Wr        (MEM2_Wr),
      .WB_Wr          (WB_Wr),
      .ID_Flush       (ID_Flush),
      .EXE_Flush      (EXE_Flush),
      .MEM_Flush      (MEM_Flush),
      .MEM2_Flush     (MEM2_Flush),
      .WB_Flush       (WB_Flush),
      .Div_Start      (Div_Start),
      .Div_Cancel     (Div_Cancel),
      .Div_Busy       (Div_Busy),
      .Squash_Pending (Squash_Pending)
   );

   task automatic quiet();
      ICache_Busy  = 1'b0;
      DCache_Busy  = 1'b0;
      EXE_IsDiv    = 1'b0;
      ID_LoadUse   = 1'b0;
      EXE_Redirect = 1'b0;
      MEM_ExcValid = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      quiet();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (wr !== 6'b000000 || fl !== 5'b11111) begin
            failures++;
            $display("FAIL reset_outs c=%0d wr=%b fl=%b want wr=000000 fl=11111", c, wr, fl);
         end
         checks++;
         if ({Div_Start, Div_Cancel, Div_Busy, Squash_Pending} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_div c=%0d got=%b want=0000", c,
                     {Div_Start, Div_Cancel, Div_Busy, Squash_Pending});
         end
         next_cycle();
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (wr !== 6'b111111 || fl !== 5'b00000) begin
         failures++;
         $display("FAIL reset_release wr=%b fl=%b want wr=111111 fl=00000", wr, fl);
      end
      next_cycle();
   endtask

   task automatic test_div();
      quiet();
      for (int c = 0; c <= 36; c++) begin
         EXE_IsDiv = 1'b1;
         @(negedge clk);
         checks++;
         if (Div_Start !== (c == 0)) begin
            failures++;
            $display("FAIL div_start c=%0d got=%b want=%b", c, Div_Start, c == 0);
         end
         checks++;
         if (EXE_Wr !== (c == 36) || MEM_Flush !== (c < 36)) begin
            failures++;
            $display("FAIL div_stall c=%0d exe_wr=%b mem_flush=%b want %b %b",
                     c, EXE_Wr, MEM_Flush, c == 36, c < 36);
         end
         checks++;
         if (Div_Busy !== (c >= 1 && c <= 35)) begin
            failures++;
            $display("FAIL div_busy c=%0d got=%b want=%b", c, Div_Busy, c >= 1 && c <= 35);
         end
         next_cycle();
      end
      quiet();
      @(negedge clk);
      checks++;
      if (Div_Busy !== 1'b0 || wr !== 6'b111111) begin
         failures++;
         $display("FAIL div_after busy=%b wr=%b want 0 111111", Div_Busy, wr);
      end
      next_cycle();
   endtask

   task automatic test_div_cancel();
      quiet();
      for (int c = 0; c < 10; c++) begin
         EXE_IsDiv = 1'b1;
         next_cycle();
      end
      MEM_ExcValid = 1'b1;
      @(negedge clk);
      checks++;
      if (Div_Cancel !== 1'b1 || fl !== 5'b11100 || PC_Wr !== 1'b1) begin
         failures++;
         $display("FAIL div_cancel cancel=%b fl=%b pc_wr=%b want 1 11100 1",
                  Div_Cancel, fl, PC_Wr);
      end
      next_cycle();
      quiet();
      @(negedge clk);
      checks++;
      if (Div_Busy !== 1'b0 || Div_Cancel !== 1'b0 || wr !== 6'b111111) begin
         failures++;
         $display("FAIL div_cancel_idle busy=%b cancel=%b wr=%b want 0 0 111111",
                  Div_Busy, Div_Cancel, wr);
      end
      next_cycle();
   endtask

   task automatic test_dcache_exc();
      quiet();
      for (int c = 0; c < 5; c++) begin
         DCache_Busy  = 1'b1;
         MEM_ExcValid = 1'b1;
         @(negedge clk);
         checks++;
         if (wr !== 6'b000000 || fl !== 5'b00000) begin
            failures++;
            $display("FAIL dcache_hold c=%0d wr=%b fl=%b want 000000 00000", c, wr, fl);
         end
         next_cycle();
      end
      DCache_Busy = 1'b0;
      @(negedge clk);
      checks++;
      if (fl !== 5'b11100 || wr !== 6'b111111) begin
         failures++;
         $display("FAIL dcache_exc_fire fl=%b wr=%b want 11100 111111", fl, wr);
      end
      next_cycle();
      quiet();
   endtask

   task automatic test_redirect_squash();
      logic exp_sq;
      quiet();
      for (int c = 0; c <= 5; c++) begin
         EXE_Redirect = (c == 0);
         ICache_Busy  = (c <= 3);
         exp_sq = (c >= 1 && c <= 4);
         @(negedge clk);
         checks++;
         if (ID_Flush !== (c <= 4) || Squash_Pending !== exp_sq) begin
            failures++;
            $display("FAIL redir_squash c=%0d id_flush=%b sq=%b want %b %b",
                     c, ID_Flush, Squash_Pending, c <= 4, exp_sq);
         end
         checks++;
         if (PC_Wr !== (c == 0 || c >= 4)) begin
            failures++;
            $display("FAIL redir_pc_wr c=%0d got=%b want=%b", c, PC_Wr, c == 0 || c >= 4);
         end
         next_cycle();
      end
      quiet();
   endtask

   task automatic test_exc_squash();
      quiet();
      MEM_ExcValid = 1'b1;
      ICache_Busy  = 1'b1;
      @(negedge clk);
      checks++;
      if (fl !== 5'b11100 || Squash_Pending !== 1'b0) begin
         failures++;
         $display("FAIL exc_icache fl=%b sq=%b want 11100 0", fl, Squash_Pending);
      end
      next_cycle();
      MEM_ExcValid = 1'b0;
      ICache_Busy  = 1'b0;
      @(negedge clk);
      checks++;
      if (Squash_Pending !== 1'b1 || ID_Flush !== 1'b1 || PC_Wr !== 1'b1) begin
         failures++;
         $display("FAIL exc_squash_clr sq=%b id_flush=%b pc_wr=%b want 1 1 1",
                  Squash_Pending, ID_Flush, PC_Wr);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (Squash_Pending !== 1'b0 || ID_Flush !== 1'b0) begin
         failures++;
         $display("FAIL exc_squash_done sq=%b id_flush=%b want 0 0", Squash_Pending, ID_Flush);
      end
      next_cycle();
   endtask

   task automatic test_loaduse_redirect();
      quiet();
      ID_LoadUse   = 1'b1;
      EXE_Redirect = 1'b1;
      @(negedge clk);
      checks++;
      if (wr !== 6'b001111 || fl !== 5'b01000) begin
         failures++;
         $display("FAIL loaduse_wins wr=%b fl=%b want 001111 01000", wr, fl);
      end
      next_cycle();
      ID_LoadUse = 1'b0;
      @(negedge clk);
      checks++;
      if (wr !== 6'b111111 || fl !== 5'b10000) begin
         failures++;
         $display("FAIL redirect_next wr=%b fl=%b want 111111 10000", wr, fl);
      end
      next_cycle();
      quiet();
   endtask

   task automatic test_reset_mid_div();
      quiet();
      for (int c = 0; c < 5; c++) begin
         EXE_IsDiv = 1'b1;
         next_cycle();
      end
      rst = 1'b0;
      #1;
      checks++;
      if (Div_Busy !== 1'b0 || Div_Cancel !== 1'b0 || wr !== 6'b000000) begin
         failures++;
         $display("FAIL reset_mid_div busy=%b cancel=%b wr=%b want 0 0 000000",
                  Div_Busy, Div_Cancel, wr);
      end
      quiet();
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (Div_Busy !== 1'b0 || wr !== 6'b111111 || fl !== 5'b00000) begin
         failures++;
         $display("FAIL reset_mid_div_after busy=%b wr=%b fl=%b want 0 111111 00000",
                  Div_Busy, wr, fl);
      end
      next_cycle();
   endtask

   initial begin
      quiet();
      rst = 1'b0;
      #1;
      test_reset();
      test_div();
      test_div_cancel();
      test_dcache_exc();
      test_redirect_squash();
      test_exc_squash();
      test_loaduse_redirect();
      test_reset_mid_div();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the six-stage core (IF, ID, EXE, MEM, MEM2, WB). It turns the stall and flush sources into per-stage register write enables and flush strobes for every pipeline register, including the MEM2→WB register. Internally it runs a small FSM for the iterative divider and a pending-squash flag for front-end redirects that arrive while the ICache is busy.

Parameters:
DIV_CYCLES, 36, cycles the iterative divider needs from Div_Start to its result being valid (≥2)
CNT_W, $clog2(DIV_CYCLES), divider countdown width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
ICache_Busy  in  1  fetch miss outstanding
DCache_Busy  in  1  MEM2 data-cache miss / uncached access outstanding
EXE_IsDiv  in  1  valid div/divu in EXE
ID_LoadUse  in  1  load-use hazard on the ID instruction
EXE_Redirect  in  1  branch/jump mispredict resolved in EXE
MEM_ExcValid  in  1  exception or eret taken in MEM
PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, MEM2_Wr, WB_Wr  out  1 each  stage register write enables
ID_Flush, EXE_Flush, MEM_Flush, MEM2_Flush, WB_Flush  out  1 each  stage register clears (flush wins over Wr in the register)
Div_Start  out  1  one-cycle divider launch
Div_Cancel  out  1  one-cycle divider abort
Div_Busy  out  1  FSM in DIV
Squash_Pending  out  1  front-end squash owed

Behaviour:
- State: FSM {IDLE, DIV, DONE}, cnt[CNT_W], squash_pend. While rst=0: IDLE, cnt=0, squash_pend=0. Outputs during reset: all *_Wr=0, all *_Flush=1, Div_* =0, Squash_Pending=0.
- Outputs are combinational from state and inputs. Default (no event): all Wr=1, all Flush=0.
- Priority, highest first:
  1. DCache_Busy: all Wr=0, no flushes, FSM/cnt hold. MEM_ExcValid is ignored this cycle; MEM stays frozen, so it re-presents.
  2. MEM_ExcValid: ID_Flush=EXE_Flush=MEM_Flush=1, PC_Wr=1, MEM2/WB Wr=1. If FSM≠IDLE: Div_Cancel=1, next state IDLE. If ICache_Busy: squash_pend←1.
  3. FSM=DIV: PC_Wr=ID_Wr=EXE_Wr=0, MEM_Flush=1 (bubble), MEM2/WB Wr=1. cnt decrements; at cnt==1 go to DONE.
  4. FSM=IDLE and EXE_IsDiv: Div_Start=1, cnt←DIV_CYCLES-1, go to DIV. Stall as in DIV this cycle.
  5. ID_LoadUse: PC_Wr=ID_Wr=0, EXE_Flush=1.
  6. EXE_Redirect: PC_Wr=1, ID_Flush=1 (drops the wrong-path fetch; the delay slot already in ID proceeds). If ICache_Busy: squash_pend←1.
  7. ICache_Busy: PC_Wr=ID_Wr=0, ID_Flush=1.
- DONE: exactly one cycle with all Wr=1 so the div leaves EXE, then IDLE. EXE_IsDiv seen in DONE does not relaunch.
- squash_pend: while set, ID_Flush=1 and Squash_Pending=1. Clears on the first cycle ICache_Busy=0, with ID_Flush still asserted that cycle. DCache_Busy does not clear it.
- Latency: Div_Start to first EXE advance = DIV_CYCLES cycles.
- Async reset mid-divide returns to IDLE with no Div_Cancel pulse; the divider shares rst.

Decomposition:
- The shared package holds `typedef enum logic[1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} DivState_t` and localparam DIV_CYCLES_DEFAULT=36.
- One natural sub-module, div_seq (FSM plus countdown). The priority/output logic stays in pipe_ctrl.

Test Plan:
- Reset: rst low for 3 cycles, then high → during reset all Flush=1 and Wr=0; the first cycle after release is all Wr=1 and Flush=0.
- DIV_CYCLES=36, EXE_IsDiv=1 at cycle 0 → Div_Start at cycle 0, EXE_Wr=0 for cycles 0–35, MEM_Flush=1 for cycles 0–35, EXE_Wr=1 at cycle 36, Div_Busy high for cycles 1–35.
- MEM_ExcValid at cycle 10 of a divide → Div_Cancel=1 and ID/EXE/MEM_Flush=1 that cycle; FSM is IDLE next cycle.
- DCache_Busy held for 5 cycles with MEM_ExcValid=1 → all Wr=0 and no flushes for 5 cycles; the flush fires on cycle 6.
- EXE_Redirect with ICache_Busy held for 4 more cycles → ID_Flush=1 for all 5 cycles and Squash_Pending=1 for 4 cycles, clearing with the cycle ICache_Busy falls.
- ID_LoadUse with EXE_Redirect in the same cycle → PC_Wr=0, ID_Wr=0, EXE_Flush=1, ID_Flush=0 (load-use wins); the redirect applies next cycle.
